// File: rtl/otn_oh_inserter.sv
// Map-side OTN overhead inserter: frames client payload into 4x1041-byte frames with FAS/MFAS/BIP-8/stuff-count overhead.
// Optional feature macro: OH_BIP8_EN (BIP-8 of previous frame carried in row 0 column 7).
module otn_oh_inserter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [1:0]  i_row_cnt,
    input  logic [10:0] i_col_cnt,
    output logic        o_fpc_valid,
    output logic        o_fpc_enable,
    input  logic [7:0]  i_pld_data,
    input  logic        i_pld_valid,
    output logic        o_pld_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sof,
    input  logic        i_out_ready
);

    localparam int unsigned ROW_W   = 2;
    localparam int unsigned COL_W   = 11;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STUFF_W = 3;

    localparam logic [COL_W-1:0]  COL_PLD_FIRST = COL_W'(16);
    localparam logic [COL_W-1:0]  COL_JO        = COL_W'(1040);
    localparam logic [COL_W-1:0]  COL_JC        = COL_W'(15);
    localparam logic [ROW_W-1:0]  ROW_FIRST     = ROW_W'(0);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(3);
    localparam logic [BYTE_W-1:0] FAS_A         = BYTE_W'(8'hF6);
    localparam logic [BYTE_W-1:0] FAS_B         = BYTE_W'(8'h28);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   mfas;
    logic [STUFF_W-1:0]  stuff_cur;
    logic [STUFF_W-1:0]  stuff_prev;
`ifdef OH_BIP8_EN
    logic [BYTE_W-1:0]   bip_cur;
    logic [BYTE_W-1:0]   bip_prev;
`endif

    logic                is_oh;
    logic                is_jo;
    logic                is_pld;
    logic                at_origin;
    logic                slot;
    logic                fpc_enable;
    logic                pld_ready;
    logic                accept;
    logic                emit;
    logic                stuff_now;
    logic                frame_end;
    logic [BYTE_W-1:0]   oh_byte;
    logic [BYTE_W-1:0]   next_byte;

    // Column classification and the payload/counter handshake
    always_comb begin
        is_oh      = 1'b0;
        is_jo      = 1'b0;
        is_pld     = 1'b0;
        at_origin  = 1'b0;
        slot       = 1'b0;
        fpc_enable = 1'b0;
        pld_ready  = 1'b0;
        accept     = 1'b0;
        emit       = 1'b0;
        stuff_now  = 1'b0;
        frame_end  = 1'b0;

        is_oh      = (i_col_cnt < COL_PLD_FIRST);
        is_jo      = (i_col_cnt == COL_JO);
        is_pld     = !is_oh && !is_jo;
        at_origin  = (i_row_cnt == ROW_FIRST) && (i_col_cnt == '0);
        slot       = !o_valid || i_out_ready;
        fpc_enable = (state == ST_RUN) && slot;
        pld_ready  = fpc_enable && (is_pld || is_jo);
        accept     = pld_ready && i_pld_valid;
        emit       = fpc_enable && (is_oh || is_jo || accept);
        stuff_now  = emit && is_jo && !accept;
        frame_end  = emit && is_jo && (i_row_cnt == ROW_LAST);
    end

    // Overhead byte for the current position; previous-frame values feed MFAS/BIP/JC
    always_comb begin
        oh_byte   = '0;
        next_byte = '0;
        if (i_row_cnt == ROW_FIRST) begin
            case (i_col_cnt)
                COL_W'(0), COL_W'(1), COL_W'(2): oh_byte = FAS_A;
                COL_W'(3), COL_W'(4), COL_W'(5): oh_byte = FAS_B;
                COL_W'(6):                       oh_byte = mfas;
`ifdef OH_BIP8_EN
                COL_W'(7):                       oh_byte = bip_prev;
`endif
                default:                         oh_byte = '0;
            endcase
        end else if ((i_row_cnt == ROW_LAST) && (i_col_cnt == COL_JC)) begin
            oh_byte = {(BYTE_W - STUFF_W)'(0), stuff_prev};
        end

        if (is_oh) begin
            next_byte = oh_byte;
        end else if (accept) begin
            next_byte = i_pld_data;
        end
    end

    assign o_fpc_enable = fpc_enable;
    assign o_pld_ready  = pld_ready;
    assign o_fpc_valid  = accept;

    // Run/idle control, output register and per-frame overhead bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_sof      <= 1'b0;
            mfas       <= '0;
            stuff_cur  <= '0;
            stuff_prev <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_en && at_origin)     state <= ST_RUN;
                ST_RUN:  if (frame_end && !i_en)    state <= ST_IDLE;
                default:                            state <= ST_IDLE;
            endcase

            if (emit) begin
                o_data  <= next_byte;
                o_valid <= 1'b1;
                o_sof   <= at_origin;
            end else if (i_out_ready) begin
                o_valid <= 1'b0;
                o_sof   <= 1'b0;
            end

            // The final JO stuff of a frame is folded in before the latch
            if (frame_end) begin
                mfas       <= mfas + BYTE_W'(1);
                stuff_prev <= stuff_cur + STUFF_W'(stuff_now);
                stuff_cur  <= '0;
            end else if (stuff_now) begin
                stuff_cur  <= stuff_cur + STUFF_W'(1);
            end
        end
    end

`ifdef OH_BIP8_EN
    // Parity over accepted payload only; the final JO byte is folded in before the latch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bip_cur  <= '0;
            bip_prev <= '0;
        end else if (frame_end) begin
            bip_prev <= accept ? (bip_cur ^ i_pld_data) : bip_cur;
            bip_cur  <= '0;
        end else if (accept) begin
            bip_cur  <= bip_cur ^ i_pld_data;
        end
    end
`endif

endmodule

// File: tb/tb_otn_oh_inserter.sv
// Scoreboard bench for otn_oh_inserter: an external frame counter model, a planned payload source and a
// frame-level reference model that builds the expected byte stream directly from the frame layout rules.
module tb_otn_oh_inserter;

    localparam int SLOTS       = 4100;
    localparam int FRAME_BYTES = 4164;
    localparam int MAXF        = 3;
    localparam int MAX_WAIT    = 40000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  row_cnt;
    logic [10:0] col_cnt;
    logic        fpc_valid;
    logic        fpc_enable;
    logic [7:0]  pld_data = 8'h00;
    logic        pld_valid = 1'b0;
    logic        pld_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    otn_oh_inserter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_row_cnt    (row_cnt),
        .i_col_cnt    (col_cnt),
        .o_fpc_valid  (fpc_valid),
        .o_fpc_enable (fpc_enable),
        .i_pld_data   (pld_data),
        .i_pld_valid  (pld_valid),
        .o_pld_ready  (pld_ready),
        .o_data       (out_data),
        .o_valid      (out_valid),
        .o_sof        (out_sof),
        .i_out_ready  (out_ready)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] pld [MAXF][SLOTS];
    bit         stuff_plan [MAXF][4];
    int         nf = 0;
    int         gap_pct = 0;
    int         rdy_mode = 0;
    bit         en_req = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int scn_bytes = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int since_sof = 0;
    bit hold_pending = 1'b0;
    logic [7:0] hold_data = 8'h00;
    int frame_idx;

    // External frame position counter: advances once per byte the inserter emits
    always @(posedge clk) begin
        if (rst) begin
            row_cnt   <= 2'd0;
            col_cnt   <= 11'd0;
            frame_idx <= 0;
        end else if (fpc_enable && (col_cnt < 11'd16 || col_cnt == 11'd1040 || fpc_valid)) begin
            if (col_cnt == 11'd1040) begin
                col_cnt <= 11'd0;
                if (row_cnt == 2'd3) begin
                    row_cnt   <= 2'd0;
                    frame_idx <= frame_idx + 1;
                end else begin
                    row_cnt <= row_cnt + 2'd1;
                end
            end else begin
                col_cnt <= col_cnt + 11'd1;
            end
        end
    end

    // Payload source and downstream ready driver, indexed by the counter position
    initial begin
        int   fr;
        bit   v;
        logic [7:0] d;
        forever begin
            @(posedge clk);
            #1;
            fr = frame_idx;
            v  = 1'b0;
            d  = 8'($urandom);
            if (fr < nf && col_cnt >= 11'd16) begin
                d = pld[fr][int'(row_cnt) * 1025 + int'(col_cnt) - 16];
                if (col_cnt == 11'd1040) v = !stuff_plan[fr][row_cnt];
                else                     v = (int'($urandom_range(99)) >= gap_pct);
                if (!v) d = 8'($urandom);
            end
            pld_valid = v;
            pld_data  = d;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(99) < 75);
            endcase
            en = en_req && (fr < nf - 1 || (fr < nf && row_cnt == 2'd0 && col_cnt == 11'd0));
        end
    end

    // Monitor: pops the scoreboard on every output transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (hold_pending) begin
                    checks++;
                    if (!(out_valid && out_data == hold_data)) begin
                        errors++;
                        $display("FAIL stall_hold valid=%b data=%h required valid=1 data=%h", out_valid, out_data, hold_data);
                    end
                end
                hold_pending = out_valid && !out_ready;
                hold_data    = out_data;
                if (out_valid && out_ready) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte data=%h sof=%b required none", out_data, out_sof);
                    end else begin
                        e = expq.pop_front();
                        if (out_data !== e.d || out_sof !== e.sof) begin
                            errors++;
                            $display("FAIL byte#%0d data=%h sof=%b required data=%h sof=%b",
                                     scn_bytes, out_data, out_sof, e.d, e.sof);
                        end
                    end
                    if (out_sof) begin
                        if (since_sof > 0) begin
                            checks++;
                            if (since_sof != FRAME_BYTES) begin
                                errors++;
                                $display("FAIL frame_len got %0d required %0d", since_sof, FRAME_BYTES);
                            end
                        end
                        since_sof = 1;
                    end else begin
                        since_sof++;
                    end
                    if (scn_bytes == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    scn_bytes++;
                end
            end
        end
    end

    // Reference model: the expected byte stream of n frames from the frame layout rules
    task automatic build_expected(input int n);
        logic [7:0] mfas = 8'h00;
        logic [2:0] sc, sc_prev;
        logic [7:0] b;
`ifdef OH_BIP8_EN
        logic [7:0] bip, bip_prev;
        bip_prev = 8'h00;
`endif
        sc_prev = 3'd0;
        for (int k = 0; k < n; k++) begin
            sc = 3'd0;
`ifdef OH_BIP8_EN
            bip = 8'h00;
`endif
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 1041; c++) begin
                    b = 8'h00;
                    if (c < 16) begin
                        if (r == 0 && c < 3)        b = 8'hF6;
                        else if (r == 0 && c < 6)   b = 8'h28;
                        else if (r == 0 && c == 6)  b = mfas;
`ifdef OH_BIP8_EN
                        else if (r == 0 && c == 7)  b = bip_prev;
`endif
                        else if (r == 3 && c == 15) b = {5'b0, sc_prev};
                    end else if (c == 1040 && stuff_plan[k][r]) begin
                        sc = sc + 3'd1;
                    end else begin
                        b = pld[k][r * 1025 + c - 16];
`ifdef OH_BIP8_EN
                        bip = bip ^ b;
`endif
                    end
                    expq.push_back('{d: b, sof: (r == 0 && c == 0)});
                end
            end
            mfas    = mfas + 8'd1;
            sc_prev = sc;
`ifdef OH_BIP8_EN
            bip_prev = bip;
`endif
        end
    endtask

    task automatic idle_check();
        int bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_after_en_drop valid_cycles=%0d required 0", bad);
        end
    endtask

    // dmode: 0 incrementing, 1 random, 2 constant 0x5A; span_mult: cycles per byte expected (0 = unchecked)
    task automatic run_scn(input int n, input int dmode, input int gp, input int rm, input bit rstuff,
                           input logic [3:0] stuff0, input int reset_after, input int span_mult);
        int t;
        int span;
        int nbytes;
        @(posedge clk);
        #2;
        rst    = 1'b1;
        en_req = 1'b0;
        nf     = 0;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < SLOTS; i++) begin
                case (dmode)
                    0:       pld[k][i] = 8'(k * SLOTS + i);
                    1:       pld[k][i] = 8'($urandom);
                    default: pld[k][i] = 8'h5A;
                endcase
            end
            for (int r = 0; r < 4; r++) begin
                if (rstuff) stuff_plan[k][r] = bit'($urandom_range(1));
                else        stuff_plan[k][r] = (k == 0) ? stuff0[r] : 1'b0;
            end
        end
        expq.delete();
        build_expected(n);
        scn_bytes    = 0;
        since_sof    = 0;
        hold_pending = 1'b0;
        nf           = n;
        gap_pct      = gp;
        rdy_mode     = rm;
        en_req       = 1'b1;
        rst          = 1'b0;

        t = 0;
        while (expq.size() > 0 && t < MAX_WAIT) begin
            @(posedge clk);
            t++;
            if (reset_after > 0 && scn_bytes >= reset_after) break;
        end

        if (reset_after > 0) begin
            #2;
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid || out_sof || out_data != 8'h00 || fpc_valid || fpc_enable || pld_ready) begin
                errors++;
                $display("FAIL mid_reset valid=%b sof=%b data=%h fpcv=%b fpce=%b rdy=%b required all 0",
                         out_valid, out_sof, out_data, fpc_valid, fpc_enable, pld_ready);
            end
            expq.delete();
            return;
        end

        checks++;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout remaining=%0d required 0", expq.size());
            expq.delete();
        end

        if (span_mult > 0) begin
            nbytes = n * FRAME_BYTES;
            span   = last_cyc - first_cyc;
            checks++;
            if (span < span_mult * (nbytes - 1) - 2 || span > span_mult * (nbytes - 1) + 2) begin
                errors++;
                $display("FAIL throughput span=%0d required %0d", span, span_mult * (nbytes - 1));
            end
        end
        idle_check();
    endtask

    initial begin
        // incrementing payload, no gaps, full rate: FAS/MFAS layout, zero stuffs
        run_scn(2, 0, 0, 0, 1'b0, 4'b0000, 0, 1);
        // stuff at every JO of frame 1 with 0x5A payload: JC=4, even-count parity
        run_scn(2, 2, 0, 0, 1'b0, 4'b1111, 0, 1);
        // single stuff: odd count of 0x5A bytes
        run_scn(2, 2, 0, 0, 1'b0, 4'b0100, 0, 1);
        // payload gaps in PLD columns
        run_scn(2, 1, 20, 0, 1'b0, 4'b0000, 0, 0);
        // downstream ready toggling every cycle
        run_scn(1, 1, 0, 1, 1'b0, 4'b0000, 0, 2);
        // random gaps, random backpressure, random stuffing
        run_scn(2, 1, 15, 2, 1'b1, 4'b0000, 0, 0);
        // reset partway into the second frame, then a fresh run restarts MFAS at 0
        run_scn(2, 0, 0, 0, 1'b0, 4'b0000, 5000, 0);
        run_scn(1, 1, 10, 0, 1'b1, 4'b0000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otn_oh_inserter.md
# otn_oh_inserter

Map-side framer stage directly downstream of the frame position counter in map mode. Takes the counter's current row/column, pulls client payload bytes through a valid/ready handshake, inserts frame overhead (FAS, MFAS, BIP-8, justification count) and stuff bytes, and emits one registered byte stream per frame of 4 rows × 1041 columns. It also drives the counter's valid and enable inputs, so the counter advances exactly once per emitted byte.

## Interface
- No parameters.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_en  in  1  run request; sampled at frame boundaries.
- i_row_cnt  in  2  current row from the frame position counter.
- i_col_cnt  in  11  current column from the frame position counter, 0..1040.
- o_fpc_valid  out  1  payload byte accepted this cycle; drives the counter's valid input.
- o_fpc_enable  out  1  counter advance permitted; drives the counter's enable input.
- i_pld_data  in  8  client payload byte.
- i_pld_valid  in  1  payload byte available.
- o_pld_ready  out  1  payload byte may be taken.
- o_data  out  8  framed output byte.
- o_valid  out  1  o_data valid.
- o_sof  out  1  o_data is row 0, column 0.
- i_out_ready  in  1  downstream accepts o_data.

## Operation
- Column classes:
  - OH: columns 0–15.
  - PLD: columns 16–1039.
  - JO: column 1040, the justification opportunity.
- FSM has two states, IDLE and RUN.
  - IDLE→RUN when i_en=1 and the counter is at row 0, column 0.
  - RUN→IDLE when the row 3 / column 1040 byte is emitted while i_en=0.
  - Deasserting i_en never truncates a frame.
- slot = (!o_valid || i_out_ready).
- o_fpc_enable = RUN && slot.
- o_pld_ready = o_fpc_enable && column in PLD or JO.
- accept = o_pld_ready && i_pld_valid; o_fpc_valid = accept.
- emit = o_fpc_enable && (OH || JO || accept). In PLD without accept: no emit, and the counter holds.
- Emitted byte by position:
  - Row 0, columns 0–2: 0xF6. Row 0, columns 3–5: 0x28.
  - Row 0, column 6: MFAS.
  - Row 0, column 7: BIP-8 of the previous frame.
  - Row 3, column 15: {5'b0, stuff count of the previous frame}.
  - Any other OH byte: 0x00.
  - PLD: i_pld_data.
  - JO: i_pld_data if accept, else stuff byte 0x00. A stuff byte increments the current-frame stuff count (0..4, 3-bit).
- BIP-8: XOR of every accepted payload byte in the current frame. Stuff bytes and OH bytes are excluded.
- Frame end (row 3 / column 1040 emitted):
  - MFAS increments, wrapping 255→0.
  - Current BIP and stuff count latch into the previous-frame registers.
  - Current BIP and stuff count accumulators clear; the JO byte of this cycle is included before the latch.
- Reset values:
  - All outputs 0; o_data=0x00.
  - State IDLE; MFAS=0.
  - BIP-8 and stuff count, current and previous, all 0.
  - Reset mid-frame abandons the frame. The counter resets on the same i_rst, so restart begins at row 0, column 0.

## Timing
- Output register: on emit, o_data, o_valid=1 and o_sof load at the next edge. Latency from position/accept to o_valid is 1 cycle.
- o_valid && !i_out_ready: o_data, o_valid and o_sof hold; o_fpc_enable=0; o_pld_ready=0.
- o_valid && i_out_ready && !emit: o_valid clears at the next edge.
- Full throughput: one byte per cycle while i_out_ready=1 and payload is available.
- o_fpc_valid, o_fpc_enable and o_pld_ready are combinational from registered state, i_row_cnt, i_col_cnt, i_pld_valid, i_out_ready and o_valid. There is no combinational path from i_pld_data.
- MFAS, BIP and stuff registers update on the same edge that the frame-end byte loads into the output register. The next frame's row 0, column 6 and column 7 bytes see the new values.

## Configuration
- OH_BIP8_EN defined: BIP-8 accumulate/latch logic is present, and row 0 column 7 carries the previous-frame BIP-8.
- OH_BIP8_EN undefined: no parity logic, and row 0 column 7 carries 0x00. All other behaviour is unchanged.

## Test plan
- Reset, i_en=1, payload always valid (incrementing byte), i_out_ready=1:
  - First 8 bytes out are F6 F6 F6 28 28 28 00 00 with o_sof on the first.
  - 4164 bytes per frame; zero stuffs; second frame row 0 column 6 = 0x01.
- Payload valid low exactly at each JO column of frame 1:
  - Four 0x00 stuff bytes emitted at column 1040 with no stall.
  - Frame 2, row 3 column 15 = 0x04.
- Payload gaps in PLD columns: o_valid low for each gap; counter column unchanged; no byte lost or duplicated.
- i_out_ready toggling 1/0 every cycle mid-payload: o_data stable while stalled; payload order intact; throughput one byte per two cycles.
- With OH_BIP8_EN, known frame 1 payload (all 0x5A, 4100 accepted bytes): frame 2, row 0 column 7 = 0x00. With an odd count, 0x5A. Without the macro: 0x00 always.
- Mid-frame events:
  - i_en dropped mid-frame: the frame completes, then o_valid stays 0.
  - i_rst mid-frame: all outputs 0 next cycle, MFAS restarts at 0x00.
